ysyx_23060075_axi_arbiter: RTL and testbench

- Shares the single AXI-lite SRAM slave between two masters: M0 = IFU (read-only) and M1 = LSU (read and write).
- Sits between the IFU/LSU and the SRAM slave; at most one transaction is outstanding at the slave.
- A registered FSM grants one master, forwards that master's channels combinationally, and releases the grant on the final R or B handshake.

---
 rtl/ysyx_23060075_axi_arbiter_pkg.sv | 17 +
 rtl/ysyx_23060075_axi_arbiter_if.sv | 44 ++++
 rtl/ysyx_23060075_axi_arbiter_sel.sv | 43 ++++
 rtl/ysyx_23060075_axi_arbiter.sv | 168 ++++++++++++++++
 tb/tb_ysyx_23060075_axi_arbiter.sv | 628 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_23060075_axi_arbiter_pkg.sv
// Shared types for the AXI-lite SRAM arbiter.
// FSM state encoding, master indices and default bus width.
package ysyx_23060075_axi_arbiter_pkg;

  localparam int ISA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD0  = 2'd1,
    ST_RD1  = 2'd2,
    ST_WR1  = 2'd3
  } arb_state_e;

  localparam logic MST_M0 = 1'b0;
  localparam logic MST_M1 = 1'b1;

endpackage

// File: rtl/ysyx_23060075_axi_arbiter_if.sv
// AXI-lite link (AR/R/AW/W/B) between one requester and one responder.
// master: requester view; slave: responder view.
interface ysyx_23060075_axi_arbiter_if
  import ysyx_23060075_axi_arbiter_pkg::*;
#(
  parameter int W = ISA_WIDTH
);
  logic [W-1:0] araddr;
  logic         arvalid;
  logic         arready;
  logic [W-1:0] rdata;
  logic [W-1:0] rresp;
  logic         rvalid;
  logic         rready;
  logic [W-1:0] awaddr;
  logic         awvalid;
  logic         awready;
  logic [W-1:0] wdata;
  logic [W-1:0] wstrb;
  logic         wvalid;
  logic         wready;
  logic [W-1:0] bresp;
  logic         bvalid;
  logic         bready;

  modport master (
    output araddr, arvalid, rready,
    output awaddr, awvalid,
    output wdata, wstrb, wvalid,
    output bready,
    input  arready, rdata, rresp, rvalid,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    input  awaddr, awvalid,
    input  wdata, wstrb, wvalid,
    input  bready,
    output arready, rdata, rresp, rvalid,
    output awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/ysyx_23060075_axi_arbiter_sel.sv
// Grant select: maps IDLE request lines to the next FSM state.
// Fixed priority by default; YSYX_23060075_ARB_RR_EN alternates reads.
module ysyx_23060075_axi_arbiter_sel
  import ysyx_23060075_axi_arbiter_pkg::*;
(
  input  logic       m1_awvalid,
  input  logic       m1_arvalid,
  input  logic       m0_arvalid,
  input  logic       last_rd,
  output arb_state_e grant_state
);

`ifdef YSYX_23060075_ARB_RR_EN
  always_comb begin
    grant_state = ST_IDLE;
    if (m1_awvalid) begin
      grant_state = ST_WR1;
    end else if (m1_arvalid && m0_arvalid) begin
      // both reading: whoever was not served last wins
      grant_state = (last_rd == MST_M1) ? ST_RD0 : ST_RD1;
    end else if (m1_arvalid) begin
      grant_state = ST_RD1;
    end else if (m0_arvalid) begin
      grant_state = ST_RD0;
    end
  end
`else
  logic unused_last_rd;
  assign unused_last_rd = last_rd;

  always_comb begin
    grant_state = ST_IDLE;
    if (m1_awvalid) begin
      grant_state = ST_WR1;
    end else if (m1_arvalid) begin
      grant_state = ST_RD1;
    end else if (m0_arvalid) begin
      grant_state = ST_RD0;
    end
  end
`endif

endmodule

// File: rtl/ysyx_23060075_axi_arbiter.sv
// Two-master AXI-lite arbiter (M0 = IFU read-only, M1 = LSU) onto one SRAM.
// Ports: clk, rst (sync, active-low), m0/m1 slave links, s master link.
// Macro YSYX_23060075_ARB_RR_EN enables round-robin between reads.
module ysyx_23060075_axi_arbiter
  import ysyx_23060075_axi_arbiter_pkg::*;
#(
  parameter int W = ISA_WIDTH
)
(
  input logic                         clk,
  input logic                         rst,
  ysyx_23060075_axi_arbiter_if.slave  m0,
  ysyx_23060075_axi_arbiter_if.slave  m1,
  ysyx_23060075_axi_arbiter_if.master s
);

  localparam logic [W-1:0] ZERO = '0;

  arb_state_e state_q, state_d;
  arb_state_e sel_state;
  logic ar_done_q, ar_done_d;
  logic aw_done_q, aw_done_d;
  logic w_done_q, w_done_d;
  logic last_rd;

  // M0 never writes
  logic unused_m0;
  assign unused_m0 = ^{m0.awaddr, m0.awvalid, m0.wdata,
                       m0.wstrb, m0.wvalid, m0.bready};

  ysyx_23060075_axi_arbiter_sel u_sel (
    .m1_awvalid  (m1.awvalid),
    .m1_arvalid  (m1.arvalid),
    .m0_arvalid  (m0.arvalid),
    .last_rd     (last_rd),
    .grant_state (sel_state)
  );

`ifdef YSYX_23060075_ARB_RR_EN
  logic last_rd_q, last_rd_d;

  always_comb begin
    last_rd_d = last_rd_q;
    if (state_q == ST_IDLE) begin
      if (sel_state == ST_RD0) last_rd_d = MST_M0;
      if (sel_state == ST_RD1) last_rd_d = MST_M1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) last_rd_q <= MST_M0;
    else      last_rd_q <= last_rd_d;
  end

  assign last_rd = last_rd_q;
`else
  assign last_rd = MST_M0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      ar_done_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ar_done_q <= ar_done_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ar_done_d = ar_done_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    m0.arready = 1'b0;
    m0.rdata   = ZERO;
    m0.rresp   = ZERO;
    m0.rvalid  = 1'b0;
    m0.awready = 1'b0;
    m0.wready  = 1'b0;
    m0.bresp   = ZERO;
    m0.bvalid  = 1'b0;

    m1.arready = 1'b0;
    m1.rdata   = ZERO;
    m1.rresp   = ZERO;
    m1.rvalid  = 1'b0;
    m1.awready = 1'b0;
    m1.wready  = 1'b0;
    m1.bresp   = ZERO;
    m1.bvalid  = 1'b0;

    s.araddr  = ZERO;
    s.arvalid = 1'b0;
    s.rready  = 1'b0;
    s.awaddr  = ZERO;
    s.awvalid = 1'b0;
    s.wdata   = ZERO;
    s.wstrb   = ZERO;
    s.wvalid  = 1'b0;
    s.bready  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // grant lands next cycle; nothing is forwarded here
        state_d = sel_state;
      end

      ST_RD0: begin
        s.araddr   = m0.araddr;
        s.arvalid  = m0.arvalid & ~ar_done_q;
        m0.arready = s.arready & ~ar_done_q;
        m0.rdata   = s.rdata;
        m0.rresp   = s.rresp;
        m0.rvalid  = s.rvalid;
        s.rready   = m0.rready;
        if (m0.arvalid & s.arready & ~ar_done_q) ar_done_d = 1'b1;
        if (s.rvalid & m0.rready) begin
          state_d   = ST_IDLE;
          ar_done_d = 1'b0;
        end
      end

      ST_RD1: begin
        s.araddr   = m1.araddr;
        s.arvalid  = m1.arvalid & ~ar_done_q;
        m1.arready = s.arready & ~ar_done_q;
        m1.rdata   = s.rdata;
        m1.rresp   = s.rresp;
        m1.rvalid  = s.rvalid;
        s.rready   = m1.rready;
        if (m1.arvalid & s.arready & ~ar_done_q) ar_done_d = 1'b1;
        if (s.rvalid & m1.rready) begin
          state_d   = ST_IDLE;
          ar_done_d = 1'b0;
        end
      end

      ST_WR1: begin
        s.awaddr   = m1.awaddr;
        s.awvalid  = m1.awvalid & ~aw_done_q;
        m1.awready = s.awready & ~aw_done_q;
        s.wdata    = m1.wdata;
        s.wstrb    = m1.wstrb;
        s.wvalid   = m1.wvalid & ~w_done_q;
        m1.wready  = s.wready & ~w_done_q;
        m1.bresp   = s.bresp;
        m1.bvalid  = s.bvalid;
        s.bready   = m1.bready;
        if (m1.awvalid & s.awready & ~aw_done_q) aw_done_d = 1'b1;
        if (m1.wvalid & s.wready & ~w_done_q) w_done_d = 1'b1;
        if (s.bvalid & m1.bready) begin
          state_d   = ST_IDLE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060075_axi_arbiter.sv
// Directed bench for ysyx_23060075_axi_arbiter.
// Drives both masters and an SRAM responder from one process.
module tb_ysyx_23060075_axi_arbiter;
  import ysyx_23060075_axi_arbiter_pkg::*;

  logic clk;
  logic rst;

  ysyx_23060075_axi_arbiter_if #(.W(32)) m0_if ();
  ysyx_23060075_axi_arbiter_if #(.W(32)) m1_if ();
  ysyx_23060075_axi_arbiter_if #(.W(32)) s_if ();

  ysyx_23060075_axi_arbiter #(.W(32)) dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0_if),
    .m1  (m1_if),
    .s   (s_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec;
  int err;

  logic [31:0] mem [0:63];
  int          lat_r;
  logic        rd_pend;
  int          rd_cnt;
  logic [31:0] rd_addr;
  logic        aw_got;
  logic        w_got;
  logic [31:0] wa;
  logic [31:0] wd;
  logic [31:0] ws;

  int s_ar_cnt;
  int s_aw_cnt;
  int s_w_cnt;
  int m0_rd_cnt;
  int m1_rd_cnt;
  int m1_b_cnt;
  logic [31:0] m0_last;
  logic [31:0] m1_last;
  int order_q[$];

  // One clock: sample handshakes before the edge, update after it.
  task automatic tick();
    logic ar0, r0, ar1, r1, aw1, w1, b1;
    logic sar, sr, saw, sw, sb, rl;
    logic [31:0] r0d, r1d, sara, sawa, swd, sws;
    int idx;
    @(negedge clk);
    ar0  = m0_if.arvalid & m0_if.arready;
    r0   = m0_if.rvalid & m0_if.rready;
    r0d  = m0_if.rdata;
    ar1  = m1_if.arvalid & m1_if.arready;
    r1   = m1_if.rvalid & m1_if.rready;
    r1d  = m1_if.rdata;
    aw1  = m1_if.awvalid & m1_if.awready;
    w1   = m1_if.wvalid & m1_if.wready;
    b1   = m1_if.bvalid & m1_if.bready;
    sar  = s_if.arvalid & s_if.arready;
    sara = s_if.araddr;
    sr   = s_if.rvalid & s_if.rready;
    saw  = s_if.awvalid & s_if.awready;
    sawa = s_if.awaddr;
    sw   = s_if.wvalid & s_if.wready;
    swd  = s_if.wdata;
    sws  = s_if.wstrb;
    sb   = s_if.bvalid & s_if.bready;
    rl   = ~rst;
    @(posedge clk);
    #1;
    if (rl) begin
      m0_if.arvalid = 1'b0;
      m1_if.arvalid = 1'b0;
      m1_if.awvalid = 1'b0;
      m1_if.wvalid  = 1'b0;
      s_if.arready  = 1'b1;
      s_if.rvalid   = 1'b0;
      s_if.rdata    = '0;
      s_if.awready  = 1'b1;
      s_if.wready   = 1'b1;
      s_if.bvalid   = 1'b0;
      rd_pend = 1'b0;
      aw_got  = 1'b0;
      w_got   = 1'b0;
    end else begin
      if (ar0) m0_if.arvalid = 1'b0;
      if (ar1) m1_if.arvalid = 1'b0;
      if (aw1) m1_if.awvalid = 1'b0;
      if (w1)  m1_if.wvalid  = 1'b0;
      if (r0) begin
        m0_rd_cnt++;
        m0_last = r0d;
        order_q.push_back(0);
      end
      if (r1) begin
        m1_rd_cnt++;
        m1_last = r1d;
        order_q.push_back(1);
      end
      if (b1) begin
        m1_b_cnt++;
        order_q.push_back(2);
      end
      if (sr) begin
        s_if.rvalid  = 1'b0;
        s_if.rdata   = '0;
        s_if.arready = 1'b1;
        rd_pend      = 1'b0;
      end
      if (sar) begin
        s_ar_cnt++;
        rd_pend      = 1'b1;
        rd_cnt       = lat_r;
        rd_addr      = sara;
        s_if.arready = 1'b0;
      end else if (rd_pend && !s_if.rvalid) begin
        if (rd_cnt > 1) begin
          rd_cnt--;
        end else begin
          s_if.rvalid = 1'b1;
          s_if.rdata  = mem[rd_addr[7:2]];
        end
      end
      if (sb) begin
        s_if.bvalid  = 1'b0;
        s_if.awready = 1'b1;
        s_if.wready  = 1'b1;
        aw_got = 1'b0;
        w_got  = 1'b0;
      end
      if (saw) begin
        s_aw_cnt++;
        aw_got       = 1'b1;
        wa           = sawa;
        s_if.awready = 1'b0;
      end
      if (sw) begin
        s_w_cnt++;
        w_got       = 1'b1;
        wd          = swd;
        ws          = sws;
        s_if.wready = 1'b0;
      end
      if (aw_got && w_got && !s_if.bvalid) begin
        idx = int'(wa[7:2]);
        for (int i = 0; i < 4; i++)
          if (ws[i]) mem[idx][8*i +: 8] = wd[8*i +: 8];
        s_if.bvalid = 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    vec++;
    if (dut.state_q !== ST_IDLE) begin
      err++;
      $display("FAIL rst_state: got %0d want %0d", dut.state_q, ST_IDLE);
    end
    vec++;
    if ({dut.ar_done_q, dut.aw_done_q, dut.w_done_q} !== 3'b000) begin
      err++;
      $display("FAIL rst_flags: got %b want 000",
               {dut.ar_done_q, dut.aw_done_q, dut.w_done_q});
    end
    // a pending request must not leak through in IDLE
    m0_if.araddr  = 32'h8000_0000;
    m0_if.arvalid = 1'b1;
    m1_if.awvalid = 1'b1;
    m1_if.wvalid  = 1'b1;
    m1_if.awaddr  = 32'h8000_0040;
    #1;
    vec++;
    if ({s_if.arvalid, s_if.awvalid, s_if.wvalid, s_if.rready, s_if.bready}
        !== 5'b0) begin
      err++;
      $display("FAIL idle_s_valids: got %b want 00000",
               {s_if.arvalid, s_if.awvalid, s_if.wvalid,
                s_if.rready, s_if.bready});
    end
    vec++;
    if ({m0_if.arready, m1_if.arready, m1_if.awready, m1_if.wready,
         m0_if.rvalid, m1_if.rvalid, m1_if.bvalid} !== 7'b0) begin
      err++;
      $display("FAIL idle_m_valids: got %b want 0000000",
               {m0_if.arready, m1_if.arready, m1_if.awready,
                m1_if.wready, m0_if.rvalid, m1_if.rvalid, m1_if.bvalid});
    end
    vec++;
    if ((s_if.araddr | s_if.awaddr | s_if.wdata) !== 32'h0) begin
      err++;
      $display("FAIL idle_s_data: got %h want 0",
               s_if.araddr | s_if.awaddr | s_if.wdata);
    end
    m0_if.arvalid = 1'b0;
    m1_if.awvalid = 1'b0;
    m1_if.wvalid  = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_m0_read();
    int n;
    int c;
    c = m0_rd_cnt;
    lat_r = 3;
    m0_if.araddr  = 32'h8000_0000;
    m0_if.arvalid = 1'b1;
    #1;
    vec++;
    if (s_if.arvalid !== 1'b0 || m0_if.arready !== 1'b0) begin
      err++;
      $display("FAIL m0_bubble: got arvalid=%b arready=%b want 0 0",
               s_if.arvalid, m0_if.arready);
    end
    tick();
    vec++;
    if (s_if.arvalid !== 1'b1 || s_if.araddr !== 32'h8000_0000) begin
      err++;
      $display("FAIL m0_ar_fwd: got %b/%h want 1/80000000",
               s_if.arvalid, s_if.araddr);
    end
    tick();
    vec++;
    if (s_if.arvalid !== 1'b0 || dut.ar_done_q !== 1'b1) begin
      err++;
      $display("FAIL m0_ar_done: got arvalid=%b done=%b want 0 1",
               s_if.arvalid, dut.ar_done_q);
    end
    n = 0;
    while (m0_if.rvalid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    vec++;
    if (m0_if.rvalid !== 1'b1 || m0_if.rdata !== 32'h0000_0413) begin
      err++;
      $display("FAIL m0_rdata: got %b/%h want 1/00000413",
               m0_if.rvalid, m0_if.rdata);
    end
    tick();
    vec++;
    if (dut.state_q !== ST_IDLE || m0_rd_cnt !== c + 1) begin
      err++;
      $display("FAIL m0_done: got state=%0d cnt=%0d want 0 %0d",
               dut.state_q, m0_rd_cnt, c + 1);
    end
  endtask

  task automatic test_arb_reads();
    int n;
    int c0;
    int c1;
    int exp_first;
`ifdef YSYX_23060075_ARB_RR_EN
    exp_first = 0;
`else
    exp_first = 1;
`endif
    lat_r = 2;
    c1 = m1_rd_cnt;
    m1_if.araddr  = 32'h8000_0008;
    m1_if.arvalid = 1'b1;
    n = 0;
    while (m1_rd_cnt == c1 && n < 30) begin
      tick();
      n++;
    end
    vec++;
    if (m1_rd_cnt !== c1 + 1 || m1_last !== 32'h2222_2222) begin
      err++;
      $display("FAIL m1_read: got cnt=%0d data=%h want %0d 22222222",
               m1_rd_cnt, m1_last, c1 + 1);
    end
    c0 = m0_rd_cnt;
    c1 = m1_rd_cnt;
    order_q.delete();
    m0_if.araddr  = 32'h8000_0004;
    m0_if.arvalid = 1'b1;
    m1_if.araddr  = 32'h8000_0008;
    m1_if.arvalid = 1'b1;
    tick();
    vec++;
    if (s_if.araddr !== (exp_first == 1 ? 32'h8000_0008 : 32'h8000_0004))
    begin
      err++;
      $display("FAIL both_grant_addr: got %h want first master %0d",
               s_if.araddr, exp_first);
    end
    n = 0;
    while ((m0_rd_cnt == c0 || m1_rd_cnt == c1) && n < 40) begin
      tick();
      n++;
    end
    vec++;
    if (order_q.size() != 2) begin
      err++;
      $display("FAIL both_count: got %0d want 2", order_q.size());
    end else if (order_q[0] != exp_first || order_q[1] != 1 - exp_first)
    begin
      err++;
      $display("FAIL both_order: got %0d,%0d want %0d,%0d",
               order_q[0], order_q[1], exp_first, 1 - exp_first);
    end
    vec++;
    if (m0_last !== 32'h1111_1111 || m1_last !== 32'h2222_2222) begin
      err++;
      $display("FAIL both_data: got %h %h want 11111111 22222222",
               m0_last, m1_last);
    end
  endtask

  task automatic test_write();
    int n;
    int cb;
    int caw;
    int cw;
    int c1;
    logic bseen;
    cb  = m1_b_cnt;
    caw = s_aw_cnt;
    cw  = s_w_cnt;
    bseen = 1'b0;
    m1_if.awaddr  = 32'h8000_0010;
    m1_if.awvalid = 1'b1;
    m1_if.wdata   = 32'hDEAD_BEEF;
    m1_if.wstrb   = 32'h0000_000F;
    m1_if.wvalid  = 1'b0;
    tick();
    vec++;
    if (s_if.awvalid !== 1'b1 || s_if.wvalid !== 1'b0) begin
      err++;
      $display("FAIL wr_aw_fwd: got aw=%b w=%b want 1 0",
               s_if.awvalid, s_if.wvalid);
    end
    tick();
    vec++;
    if (s_if.awvalid !== 1'b0 || dut.aw_done_q !== 1'b1) begin
      err++;
      $display("FAIL wr_aw_done: got aw=%b done=%b want 0 1",
               s_if.awvalid, dut.aw_done_q);
    end
    m1_if.wvalid = 1'b1;
    n = 0;
    while (m1_b_cnt == cb && n < 20) begin
      if (m1_if.bvalid === 1'b1) bseen = 1'b1;
      tick();
      n++;
    end
    vec++;
    if (bseen !== 1'b1 || m1_b_cnt !== cb + 1) begin
      err++;
      $display("FAIL wr_b: got seen=%b cnt=%0d want 1 %0d",
               bseen, m1_b_cnt, cb + 1);
    end
    vec++;
    if (s_aw_cnt - caw != 1 || s_w_cnt - cw != 1) begin
      err++;
      $display("FAIL wr_hs_count: got aw=%0d w=%0d want 1 1",
               s_aw_cnt - caw, s_w_cnt - cw);
    end
    c1 = m1_rd_cnt;
    m1_if.araddr  = 32'h8000_0010;
    m1_if.arvalid = 1'b1;
    n = 0;
    while (m1_rd_cnt == c1 && n < 30) begin
      tick();
      n++;
    end
    vec++;
    if (m1_last !== 32'hDEAD_BEEF) begin
      err++;
      $display("FAIL wr_readback: got %h want deadbeef", m1_last);
    end
  endtask

  task automatic test_wr_vs_rd();
    int n;
    int cb;
    int c0;
    int c1;
    logic leak;
    cb = m1_b_cnt;
    c0 = m0_rd_cnt;
    leak = 1'b0;
    order_q.delete();
    m1_if.awaddr  = 32'h8000_0014;
    m1_if.awvalid = 1'b1;
    m1_if.wdata   = 32'h1234_5678;
    m1_if.wstrb   = 32'h0000_0003;
    m1_if.wvalid  = 1'b1;
    m0_if.araddr  = 32'h8000_0000;
    m0_if.arvalid = 1'b1;
    tick();
    vec++;
    if (dut.state_q !== ST_WR1) begin
      err++;
      $display("FAIL wr_prio: got %0d want %0d", dut.state_q, ST_WR1);
    end
    n = 0;
    while (m1_b_cnt == cb && n < 20) begin
      if (m0_if.arready !== 1'b0 || s_if.arvalid !== 1'b0) leak = 1'b1;
      tick();
      n++;
    end
    vec++;
    if (leak !== 1'b0 || m1_b_cnt !== cb + 1) begin
      err++;
      $display("FAIL wr_block_m0: got leak=%b cnt=%0d want 0 %0d",
               leak, m1_b_cnt, cb + 1);
    end
    vec++;
    if (dut.state_q !== ST_IDLE) begin
      err++;
      $display("FAIL wr_release: got %0d want %0d", dut.state_q, ST_IDLE);
    end
    tick();
    vec++;
    if (dut.state_q !== ST_RD0 || s_if.araddr !== 32'h8000_0000) begin
      err++;
      $display("FAIL wr_then_m0: got %0d/%h want %0d/80000000",
               dut.state_q, s_if.araddr, ST_RD0);
    end
    n = 0;
    while (m0_rd_cnt == c0 && n < 20) begin
      tick();
      n++;
    end
    vec++;
    if (m0_rd_cnt !== c0 + 1 || m0_last !== 32'h0000_0413) begin
      err++;
      $display("FAIL wr_then_m0_data: got %0d/%h want %0d/00000413",
               m0_rd_cnt, m0_last, c0 + 1);
    end
    c1 = m1_rd_cnt;
    m1_if.araddr  = 32'h8000_0014;
    m1_if.arvalid = 1'b1;
    n = 0;
    while (m1_rd_cnt == c1 && n < 30) begin
      tick();
      n++;
    end
    vec++;
    if (m1_last !== 32'h0000_5678) begin
      err++;
      $display("FAIL wr_strobe: got %h want 00005678", m1_last);
    end
  endtask

  task automatic test_rready_hold();
    int n;
    int c0;
    int c1;
    int car;
    c0  = m0_rd_cnt;
    c1  = m1_rd_cnt;
    car = s_ar_cnt;
    lat_r = 1;
    m0_if.rready  = 1'b0;
    m0_if.araddr  = 32'h8000_0000;
    m0_if.arvalid = 1'b1;
    n = 0;
    while (m0_if.rvalid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    m1_if.araddr  = 32'h8000_0008;
    m1_if.arvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      vec++;
      if (m0_if.rvalid !== 1'b1 || m0_if.rdata !== 32'h0000_0413) begin
        err++;
        $display("FAIL hold_r[%0d]: got %b/%h want 1/00000413",
                 k, m0_if.rvalid, m0_if.rdata);
      end
      vec++;
      if (s_if.arvalid !== 1'b0 || m1_if.arready !== 1'b0 ||
          dut.state_q !== ST_RD0) begin
        err++;
        $display("FAIL hold_grant[%0d]: got ar=%b m1rdy=%b st=%0d",
                 k, s_if.arvalid, m1_if.arready, dut.state_q);
      end
      tick();
    end
    m0_if.rready = 1'b1;
    tick();
    vec++;
    if (m0_rd_cnt !== c0 + 1 || dut.state_q !== ST_IDLE) begin
      err++;
      $display("FAIL hold_release: got cnt=%0d st=%0d want %0d 0",
               m0_rd_cnt, dut.state_q, c0 + 1);
    end
    n = 0;
    while (m1_rd_cnt == c1 && n < 20) begin
      tick();
      n++;
    end
    vec++;
    if (s_ar_cnt - car != 2 || m1_last !== 32'h2222_2222) begin
      err++;
      $display("FAIL hold_ar_count: got %0d/%h want 2/22222222",
               s_ar_cnt - car, m1_last);
    end
  endtask

  task automatic test_reset_mid();
    int c1;
    c1 = m1_rd_cnt;
    lat_r = 5;
    m1_if.araddr  = 32'h8000_0008;
    m1_if.arvalid = 1'b1;
    tick();
    tick();
    vec++;
    if (dut.state_q !== ST_RD1 || dut.ar_done_q !== 1'b1) begin
      err++;
      $display("FAIL mid_pre: got st=%0d done=%b want %0d 1",
               dut.state_q, dut.ar_done_q, ST_RD1);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    vec++;
    if (dut.state_q !== ST_IDLE || dut.ar_done_q !== 1'b0) begin
      err++;
      $display("FAIL mid_rst: got st=%0d done=%b want 0 0",
               dut.state_q, dut.ar_done_q);
    end
    vec++;
    if ({s_if.arvalid, s_if.rready, m1_if.rvalid, m1_if.arready}
        !== 4'b0) begin
      err++;
      $display("FAIL mid_valids: got %b want 0000",
               {s_if.arvalid, s_if.rready, m1_if.rvalid, m1_if.arready});
    end
    tick();
    tick();
    tick();
    vec++;
    if (dut.state_q !== ST_IDLE || m1_rd_cnt !== c1) begin
      err++;
      $display("FAIL mid_quiet: got st=%0d cnt=%0d want 0 %0d",
               dut.state_q, m1_rd_cnt, c1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec = 0;
    err = 0;
    s_ar_cnt = 0;
    s_aw_cnt = 0;
    s_w_cnt  = 0;
    m0_rd_cnt = 0;
    m1_rd_cnt = 0;
    m1_b_cnt  = 0;
    m0_last = '0;
    m1_last = '0;
    lat_r   = 1;
    rd_pend = 1'b0;
    rd_cnt  = 0;
    rd_addr = '0;
    aw_got  = 1'b0;
    w_got   = 1'b0;
    wa = '0;
    wd = '0;
    ws = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[0] = 32'h0000_0413;
    mem[1] = 32'h1111_1111;
    mem[2] = 32'h2222_2222;

    rst = 1'b0;
    m0_if.araddr  = '0;
    m0_if.arvalid = 1'b0;
    m0_if.rready  = 1'b1;
    m0_if.awaddr  = '0;
    m0_if.awvalid = 1'b0;
    m0_if.wdata   = '0;
    m0_if.wstrb   = '0;
    m0_if.wvalid  = 1'b0;
    m0_if.bready  = 1'b0;
    m1_if.araddr  = '0;
    m1_if.arvalid = 1'b0;
    m1_if.rready  = 1'b1;
    m1_if.awaddr  = '0;
    m1_if.awvalid = 1'b0;
    m1_if.wdata   = '0;
    m1_if.wstrb   = '0;
    m1_if.wvalid  = 1'b0;
    m1_if.bready  = 1'b1;
    s_if.arready  = 1'b1;
    s_if.rdata    = '0;
    s_if.rresp    = '0;
    s_if.rvalid   = 1'b0;
    s_if.awready  = 1'b1;
    s_if.wready   = 1'b1;
    s_if.bresp    = '0;
    s_if.bvalid   = 1'b0;

    test_reset();
    test_m0_read();
    test_arb_reads();
    test_write();
    test_wr_vs_rd();
    test_rready_hold();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
